// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory transactions with a req/ack
// handshake, aligns and extends load data, and registers the MEM/WB fields.
module mem_access_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int SIMD_DATA_WIDTH = 128,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ExMem_Valid,
  input  logic                       ExMem_WbSel,
  input  logic [SIMD_DATA_WIDTH-1:0] ExMem_AluData,
  input  logic                       ExMem_MemRd,
  input  logic                       ExMem_MemWrt,
  input  logic [2:0]                 ExMem_Funct3,
  input  logic [DATA_WIDTH-1:0]      ExMem_StoreData,
  input  logic [4:0]                 ExMem_RdAddr,
  input  logic                       ExMem_RegWrt,
  output logic                       Dmem_Req,
  output logic                       Dmem_We,
  output logic [DATA_WIDTH-1:0]      Dmem_Addr,
  output logic [DATA_WIDTH-1:0]      Dmem_WData,
  output logic [3:0]                 Dmem_ByteEn,
  input  logic                       Dmem_Ack,
  input  logic [DATA_WIDTH-1:0]      Dmem_RData,
  output logic                       Mem_Stall,
  output logic                       MemWb_Valid,
  output logic                       MemWb_WbSel,
  output logic [SIMD_DATA_WIDTH-1:0] MemWb_AluData,
  output logic [DATA_WIDTH-1:0]      MemWb_DataRd,
  output logic [4:0]                 MemWb_RdAddr,
  output logic                       MemWb_RegWrt,
  output logic                       Mem_Misalign,
  output logic                       Mem_BusErr,
  output logic                       dbg_state
);

  // Handshake: Dmem_Req is held with address/data/enables stable until the
  // cycle Dmem_Ack is high (transfer, RData valid) or the wait times out.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        memop, misaligned, timeout_hit;
  logic [1:0]  boff;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [DATA_WIDTH-1:0] load_ext;

  assign boff  = ExMem_AluData[1:0];
  assign memop = ExMem_Valid & (ExMem_MemRd | ExMem_MemWrt);

  always_comb begin
    misaligned = 1'b0;
    case (ExMem_Funct3[1:0])
      2'b01:   misaligned = boff[0];
      2'b10:   misaligned = (boff != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign Dmem_Req  = memop & ~misaligned;
  assign Dmem_We   = ExMem_MemWrt;
  assign Dmem_Addr = {ExMem_AluData[DATA_WIDTH-1:2], 2'b00};

  // wait_cnt holds the number of stall cycles already spent on this request.
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == 8'(TIMEOUT)) && !Dmem_Ack;
  assign Mem_Stall   = Dmem_Req & ~Dmem_Ack & ~timeout_hit;
  assign dbg_state   = (state == S_WAIT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    case (state)
      S_IDLE: begin
        if (Dmem_Req && !Dmem_Ack) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      S_WAIT: begin
        if (!Dmem_Req || Dmem_Ack || timeout_hit) state_nxt = S_IDLE;
        else                                      wait_cnt_nxt = wait_cnt + 8'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Dmem_WData  = ExMem_StoreData;
    Dmem_ByteEn = 4'b1111;
    if (ExMem_MemWrt) begin
      case (ExMem_Funct3[1:0])
        2'b00: begin
          Dmem_WData  = {4{ExMem_StoreData[7:0]}};
          Dmem_ByteEn = 4'b0001 << boff;
        end
        2'b01: begin
          Dmem_WData  = {2{ExMem_StoreData[15:0]}};
          Dmem_ByteEn = boff[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_byte = Dmem_RData[{boff, 3'b000} +: 8];
    load_half = boff[1] ? Dmem_RData[31:16] : Dmem_RData[15:0];
    case (ExMem_Funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_ext = Dmem_RData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      MemWb_Valid   <= 1'b0;
      MemWb_WbSel   <= 1'b0;
      MemWb_AluData <= '0;
      MemWb_DataRd  <= '0;
      MemWb_RdAddr  <= '0;
      MemWb_RegWrt  <= 1'b0;
      Mem_Misalign  <= 1'b0;
      Mem_BusErr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (Mem_Stall) begin
        MemWb_Valid  <= 1'b0;
        Mem_Misalign <= 1'b0;
        Mem_BusErr   <= 1'b0;
      end else begin
        MemWb_Valid   <= ExMem_Valid;
        MemWb_WbSel   <= ExMem_WbSel;
        MemWb_AluData <= ExMem_AluData;
        MemWb_RdAddr  <= ExMem_RdAddr;
        MemWb_RegWrt  <= ExMem_RegWrt & ~(memop & misaligned) & ~timeout_hit;
        Mem_Misalign  <= memop & misaligned;
        Mem_BusErr    <= timeout_hit;
        if (Dmem_Req && Dmem_Ack && ExMem_MemRd) MemWb_DataRd <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level reference model
// and a per-cycle compare process fed through an expectation queue.
module tb_mem_access_stage;
  localparam int DW = 32;
  localparam int SW = 128;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          ExMem_Valid, ExMem_WbSel, ExMem_MemRd, ExMem_MemWrt, ExMem_RegWrt;
  logic [SW-1:0] ExMem_AluData;
  logic [2:0]    ExMem_Funct3;
  logic [DW-1:0] ExMem_StoreData;
  logic [4:0]    ExMem_RdAddr;
  logic          Dmem_Req, Dmem_We, Dmem_Ack;
  logic [DW-1:0] Dmem_Addr, Dmem_WData, Dmem_RData;
  logic [3:0]    Dmem_ByteEn;
  logic          Mem_Stall, MemWb_Valid, MemWb_WbSel, MemWb_RegWrt;
  logic [SW-1:0] MemWb_AluData;
  logic [DW-1:0] MemWb_DataRd;
  logic [4:0]    MemWb_RdAddr;
  logic          Mem_Misalign, Mem_BusErr, dbg_state;

  mem_access_stage #(.DATA_WIDTH(DW), .SIMD_DATA_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ExMem_Valid(ExMem_Valid), .ExMem_WbSel(ExMem_WbSel), .ExMem_AluData(ExMem_AluData),
    .ExMem_MemRd(ExMem_MemRd), .ExMem_MemWrt(ExMem_MemWrt), .ExMem_Funct3(ExMem_Funct3),
    .ExMem_StoreData(ExMem_StoreData), .ExMem_RdAddr(ExMem_RdAddr), .ExMem_RegWrt(ExMem_RegWrt),
    .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr), .Dmem_WData(Dmem_WData),
    .Dmem_ByteEn(Dmem_ByteEn), .Dmem_Ack(Dmem_Ack), .Dmem_RData(Dmem_RData),
    .Mem_Stall(Mem_Stall), .MemWb_Valid(MemWb_Valid), .MemWb_WbSel(MemWb_WbSel),
    .MemWb_AluData(MemWb_AluData), .MemWb_DataRd(MemWb_DataRd), .MemWb_RdAddr(MemWb_RdAddr),
    .MemWb_RegWrt(MemWb_RegWrt), .Mem_Misalign(Mem_Misalign), .Mem_BusErr(Mem_BusErr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          req, we, stall, st;
    logic [31:0]   addr, wdata;
    logic [3:0]    be;
    logic          mv, mwb, mrw, mis, berr;
    logic [SW-1:0] malu;
    logic [31:0]   mdata;
    logic [4:0]    mrd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model of the MEM/WB register contents
  logic          m_valid, m_wbsel, m_regwrt, m_mis, m_berr;
  logic [SW-1:0] m_alu;
  logic [31:0]   m_data;
  logic [4:0]    m_rd;

  task automatic cmp(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 2'b00) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
    if (f3[1:0] == 2'b01) return {sd[15:0], sd[15:0]};
    return sd;
  endfunction

  function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (!wr || f3[1:0] == 2'b10) return 4'b1111;
    if (f3[1:0] == 2'b00) return 4'(1 << a[1:0]);
    return a[1] ? 4'b1100 : 4'b0011;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> (8 * off);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return rdata;
    endcase
  endfunction

  // compare process: one expectation per clock cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("req", Dmem_Req, e.req);
      cmp("stall", Mem_Stall, e.stall);
      cmp("state", dbg_state, e.st);
      if (e.req) begin
        cmp("we", Dmem_We, e.we);
        cmp("addr", Dmem_Addr, e.addr);
        cmp("byteen", Dmem_ByteEn, e.be);
        if (e.we) cmp("wdata", Dmem_WData, e.wdata);
      end
      cmp("wb_valid", MemWb_Valid, e.mv);
      cmp("wb_sel", MemWb_WbSel, e.mwb);
      cmp("wb_alu", MemWb_AluData, e.malu);
      cmp("wb_data", MemWb_DataRd, e.mdata);
      cmp("wb_rd", MemWb_RdAddr, e.mrd);
      cmp("wb_regwrt", MemWb_RegWrt, e.mrw);
      cmp("misalign", Mem_Misalign, e.mis);
      cmp("buserr", Mem_BusErr, e.berr);
    end
  end

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic wbsel,
                        input logic [4:0] rdaddr, input logic regwrt);
    ExMem_Valid     = v;
    ExMem_MemRd     = rd;
    ExMem_MemWrt    = wr;
    ExMem_Funct3    = f3;
    ExMem_AluData   = {$urandom, $urandom, $urandom, a};
    ExMem_StoreData = sd;
    ExMem_WbSel     = wbsel;
    ExMem_RdAddr    = rdaddr;
    ExMem_RegWrt    = regwrt;
  endtask

  // Drive one instruction to completion. d = cycles of waiting before Ack
  // (negative: never acked). abort >= 0: reset replaces cycle number 'abort'.
  task automatic run_op(input int d, input int abort, input logic fix_en, input logic [31:0] fix_rd);
    logic        memop, mis, req;
    logic [31:0] a;
    int          s;
    a     = ExMem_AluData[31:0];
    memop = ExMem_Valid & (ExMem_MemRd | ExMem_MemWrt);
    mis   = is_misaligned(ExMem_Funct3, a);
    req   = memop & ~mis;
    s     = !req ? 0 : (d < 0 ? TO : d);
    for (int k = 0; k <= s; k++) begin
      exp_t        e;
      logic        ack;
      e.mv = m_valid;   e.mwb = m_wbsel; e.malu = m_alu; e.mdata = m_data;
      e.mrd = m_rd;     e.mrw = m_regwrt; e.mis = m_mis; e.berr = m_berr;
      e.st = (k > 0);
      if (k == abort) begin
        ExMem_Valid = 1'b0;
        rst = 1'b1;
        Dmem_Ack = 1'b0;
        e.req = 1'b0; e.stall = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.be = '0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 0; m_wbsel = 0; m_alu = '0; m_data = '0; m_rd = '0;
        m_regwrt = 0; m_mis = 0; m_berr = 0;
        return;
      end
      ack = req ? (k == d) : 1'($urandom_range(0, 1));
      Dmem_Ack   = ack;
      Dmem_RData = fix_en ? fix_rd : $urandom;
      e.req   = req;
      e.we    = ExMem_MemWrt;
      e.addr  = {a[31:2], 2'b00};
      e.wdata = exp_wdata(ExMem_Funct3, ExMem_StoreData);
      e.be    = exp_be(ExMem_MemWrt, ExMem_Funct3, a);
      e.stall = (k < s);
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (k < s) begin
        m_valid = 0; m_mis = 0; m_berr = 0;
      end else begin
        m_valid  = ExMem_Valid;
        m_wbsel  = ExMem_WbSel;
        m_alu    = ExMem_AluData;
        m_rd     = ExMem_RdAddr;
        m_mis    = memop & mis;
        m_berr   = req & ~ack;
        m_regwrt = ExMem_RegWrt & ~m_mis & ~m_berr;
        if (req && ack && ExMem_MemRd) m_data = exp_load(ExMem_Funct3, a[1:0], Dmem_RData);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    Dmem_Ack = 1'b0;
    Dmem_RData = '0;
    set_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0, 0);
    m_valid = 0; m_wbsel = 0; m_alu = '0; m_data = '0; m_rd = '0;
    m_regwrt = 0; m_mis = 0; m_berr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cmp("rst_valid", MemWb_Valid, 1'b0);
    cmp("rst_alu", MemWb_AluData, '0);
    cmp("rst_req", Dmem_Req, 1'b0);
    cmp("rst_state", dbg_state, 1'b0);
    cmp("rst_buserr", Mem_BusErr, 1'b0);

    // non-memory op
    set_op(1, 0, 0, 3'b010, 32'hDEADBEEF, 32'h0, 0, 5'd5, 1);
    run_op(0, -1, 0, 0);
    cmp("alu_valid", MemWb_Valid, 1'b1);
    cmp("alu_data", MemWb_AluData[31:0], 32'hDEADBEEF);
    cmp("alu_rd", MemWb_RdAddr, 5'd5);

    // LB / LBU at 0x1003 with three wait cycles
    set_op(1, 1, 0, 3'b000, 32'h1003, 32'h0, 1, 5'd7, 1);
    run_op(3, -1, 1, 32'h80000000);
    cmp("lb_data", MemWb_DataRd, 32'hFFFFFF80);
    set_op(1, 1, 0, 3'b100, 32'h1003, 32'h0, 1, 5'd7, 1);
    run_op(3, -1, 1, 32'h80000000);
    cmp("lbu_data", MemWb_DataRd, 32'h00000080);

    // SH zero-wait
    set_op(1, 0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 0, 5'd0, 0);
    Dmem_Ack = 1'b1;
    #1;
    cmp("sh_wdata", Dmem_WData, 32'hABCDABCD);
    cmp("sh_be", Dmem_ByteEn, 4'b1100);
    cmp("sh_addr", Dmem_Addr, 32'h2000);
    cmp("sh_we", Dmem_We, 1'b1);
    cmp("sh_stall", Mem_Stall, 1'b0);
    run_op(0, -1, 0, 0);

    // misaligned LW
    set_op(1, 1, 0, 3'b010, 32'h3001, 32'h0, 1, 5'd9, 1);
    run_op(0, -1, 0, 0);
    cmp("mis_pulse", Mem_Misalign, 1'b1);
    cmp("mis_regwrt", MemWb_RegWrt, 1'b0);
    cmp("mis_valid", MemWb_Valid, 1'b1);

    // LW that never gets an Ack, then a stray Ack
    set_op(1, 1, 0, 3'b010, 32'h4000, 32'h0, 1, 5'd3, 1);
    run_op(-1, -1, 0, 0);
    cmp("to_buserr", Mem_BusErr, 1'b1);
    cmp("to_regwrt", MemWb_RegWrt, 1'b0);
    cmp("to_state", dbg_state, 1'b0);
    set_op(0, 0, 0, 3'b010, 32'h0, 32'h0, 0, 5'd0, 0);
    run_op(0, -1, 0, 0);
    cmp("stray_buserr", Mem_BusErr, 1'b0);

    // reset while waiting
    set_op(1, 1, 0, 3'b010, 32'h5000, 32'h0, 1, 5'd4, 1);
    run_op(-1, 2, 0, 0);
    cmp("rstw_state", dbg_state, 1'b0);
    cmp("rstw_req", Dmem_Req, 1'b0);
    cmp("rstw_valid", MemWb_Valid, 1'b0);
    cmp("rstw_rd", MemWb_RdAddr, 5'd0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int          kind, d, abort;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = (kind == 2) ? 3'b000 : 3'b100;
        default: f3 = (kind == 2) ? 3'b001 : 3'b101;
      endcase
      set_op(1'($urandom_range(0, 9) != 0), kind == 1, kind == 2, f3, $urandom, $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      d     = ($urandom_range(0, 59) == 0) ? -1 : $urandom_range(0, 5);
      abort = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
      run_op(d, abort, 0, 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
